// File: rtl/aes256_inv_key_sched.sv
// AES-256 key schedule: runs forward to round 14, then replays round keys 14..0 one per handshake.
// Optional: define AES_INV_KEY_IMC_EN to emit InvMixColumns(round key) for rounds 1..13.
module aes256_inv_key_sched (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [0:255] key_in,
   input  logic         key_valid,
   output logic         ready,
   output logic [0:127] rkey,
   output logic [3:0]   rkey_idx,
   output logic         rkey_valid,
   input  logic         rkey_ready
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_FWD  = 2'd1;
   localparam logic [1:0] S_OUT  = 2'd2;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         p = b[i] ? (p ^ x) : p;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Inverse is a^254 via repeated squaring, followed by the affine map.
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] inv;
      sq  = a;
      inv = 8'h01;
      for (int k = 1; k < 8; k++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] x);
      return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
   endfunction

   function automatic logic [7:0] rcon(input logic [2:0] j);
      logic [7:0] r;
      case (j)
         3'd1:    r = 8'h01;
         3'd2:    r = 8'h02;
         3'd3:    r = 8'h04;
         3'd4:    r = 8'h08;
         3'd5:    r = 8'h10;
         3'd6:    r = 8'h20;
         3'd7:    r = 8'h40;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

`ifdef AES_INV_KEY_IMC_EN
   function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
              gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
              gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
              gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
   endfunction
`endif

   logic [1:0]   state_q, state_d;
   logic [0:255] win_q, win_d;
   logic [3:0]   grp_q, grp_d;     // window base in words divided by 4
   logic [3:0]   cnt_q, cnt_d;
   logic         hs_q, hs_d;
   logic [3:0]   idx_q, idx_d;

   logic [31:0]  w_s [0:7];
   logic [3:0]   nq_s;
   logic [31:0]  sbox_in_s, rot_s, sub_s, f_s;
   logic [31:0]  fw0_s, fw1_s, fw2_s, fw3_s;
   logic [31:0]  bw0_s, bw1_s, bw2_s, bw3_s;
   logic [0:127] raw_s;

   // Split the window into words and compute the forward and backward step words.
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         w_s[i] = win_q[32*i +: 32];
      end
      if (state_q == S_FWD) begin
         sbox_in_s = w_s[7];
         nq_s      = grp_q + 4'd2;
      end else begin
         sbox_in_s = w_s[3];
         nq_s      = grp_q + 4'd1;
      end
      if (nq_s[0] == 1'b0) begin
         rot_s = {sbox_in_s[23:0], sbox_in_s[31:24]};
      end else begin
         rot_s = sbox_in_s;
      end
      sub_s = sub_word(rot_s);
      if (nq_s[0] == 1'b0) begin
         f_s = sub_s ^ {rcon(nq_s[3:1]), 24'h000000};
      end else begin
         f_s = sub_s;
      end
      fw0_s = w_s[0] ^ f_s;
      fw1_s = w_s[1] ^ fw0_s;
      fw2_s = w_s[2] ^ fw1_s;
      fw3_s = w_s[3] ^ fw2_s;
      bw0_s = w_s[4] ^ f_s;
      bw1_s = w_s[5] ^ w_s[4];
      bw2_s = w_s[6] ^ w_s[5];
      bw3_s = w_s[7] ^ w_s[6];
   end

   // Next-state logic for the IDLE / FWD / OUT sequence.
   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      grp_d   = grp_q;
      cnt_d   = cnt_q;
      hs_d    = hs_q;
      idx_d   = idx_q;
      case (state_q)
         S_IDLE: begin
            if (key_valid) begin
               win_d   = key_in;
               grp_d   = 4'd0;
               cnt_d   = 4'd0;
               state_d = S_FWD;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_FWD: begin
            win_d = {w_s[4], w_s[5], w_s[6], w_s[7], fw0_s, fw1_s, fw2_s, fw3_s};
            grp_d = grp_q + 4'd1;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd12) begin
               state_d = S_OUT;
               hs_d    = 1'b1;
               idx_d   = 4'd14;
            end else begin
               state_d = S_FWD;
            end
         end
         S_OUT: begin
            if (rkey_ready) begin
               if (idx_q == 4'd14) begin
                  hs_d  = 1'b0;
                  idx_d = 4'd13;
               end else if (idx_q == 4'd0) begin
                  state_d = S_IDLE;
               end else begin
                  win_d = {bw0_s, bw1_s, bw2_s, bw3_s, w_s[0], w_s[1], w_s[2], w_s[3]};
                  grp_d = grp_q - 4'd1;
                  idx_d = idx_q - 4'd1;
               end
            end else begin
               state_d = S_OUT;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output mux: upper half of the window only for round 14.
   always_comb begin
      raw_s = hs_q ? win_q[128:255] : win_q[0:127];
`ifdef AES_INV_KEY_IMC_EN
      if ((idx_q != 4'd0) && (idx_q != 4'd14)) begin
         rkey = {inv_mix_col(raw_s[0:31]), inv_mix_col(raw_s[32:63]),
                 inv_mix_col(raw_s[64:95]), inv_mix_col(raw_s[96:127])};
      end else begin
         rkey = raw_s;
      end
`else
      rkey = raw_s;
`endif
      ready      = (state_q == S_IDLE);
      rkey_valid = (state_q == S_OUT);
      rkey_idx   = idx_q;
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         win_q   <= 256'h0;
         grp_q   <= 4'd0;
         cnt_q   <= 4'd0;
         hs_q    <= 1'b0;
         idx_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         grp_q   <= grp_d;
         cnt_q   <= cnt_d;
         hs_q    <= hs_d;
         idx_q   <= idx_d;
      end
   end

endmodule

// File: tb/tb_aes256_inv_key_sched.sv
// Scoreboard bench for aes256_inv_key_sched: table-driven reference expansion, reversed.
module tb_aes256_inv_key_sched;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [0:255] key_in;
   logic         key_valid;
   logic         ready;
   logic [0:127] rkey;
   logic [3:0]   rkey_idx;
   logic         rkey_valid;
   logic         rkey_ready;

   int checks = 0;
   int errors = 0;
   logic [131:0] exp_q [$];
   logic [0:127] seen_key [0:14];

   localparam logic [0:2047] SBOX_TBL = 2048'h637c777bf26b6fc53001672bfed7ab76_ca82c97dfa5947f0add4a2af9ca472c0_b7fd9326363ff7cc34a5e5f171d83115_04c723c31896059a071280e2eb27b275_09832c1a1b6e5aa0523bd6b329e32f84_53d100ed20fcb15b6acbbe394a4c58cf_d0efaafb434d338545f9027f503c9fa8_51a3408f929d38f5bcb6da2110fff3d2_cd0c13ec5f974417c4a77e3d645d1973_60814fdc222a908846eeb814de5e0bdb_e0323a0a4906245cc2d3ac629195e479_e7c8376d8dd54ea96c56f4ea657aae08_ba78252e1ca6b4c6e8dd741f4bbd8b8a_703eb5664803f60e613557b986c11d9e_e1f8981169d98e949b1e87e9ce5528df_8ca1890dbfe6426841992d0fb054bb16;

   aes256_inv_key_sched dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_in     (key_in),
      .key_valid  (key_valid),
      .ready      (ready),
      .rkey       (rkey),
      .rkey_idx   (rkey_idx),
      .rkey_valid (rkey_valid),
      .rkey_ready (rkey_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [131:0] obs, input logic [131:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] m_sub(input logic [31:0] x);
      return {SBOX_TBL[int'(x[31:24])*8 +: 8], SBOX_TBL[int'(x[23:16])*8 +: 8],
              SBOX_TBL[int'(x[15:8])*8 +: 8],  SBOX_TBL[int'(x[7:0])*8 +: 8]};
   endfunction

   function automatic logic [7:0] mulc(input logic [7:0] a, input int c);
      logic [7:0] x2, x4, x8;
      x2 = xt(a); x4 = xt(x2); x8 = xt(x4);
      case (c)
         9:       return x8 ^ a;
         11:      return x8 ^ x2 ^ a;
         13:      return x8 ^ x4 ^ a;
         default: return x8 ^ x4 ^ x2;
      endcase
   endfunction

   function automatic logic [0:127] m_imc(input logic [0:127] k);
      logic [0:127] o;
      logic [7:0] a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         {a0, a1, a2, a3} = k[32*c +: 32];
         o[32*c +: 32] = {mulc(a0,14) ^ mulc(a1,11) ^ mulc(a2,13) ^ mulc(a3,9),
                          mulc(a0,9)  ^ mulc(a1,14) ^ mulc(a2,11) ^ mulc(a3,13),
                          mulc(a0,13) ^ mulc(a1,9)  ^ mulc(a2,14) ^ mulc(a3,11),
                          mulc(a0,11) ^ mulc(a1,13) ^ mulc(a2,9)  ^ mulc(a3,14)};
      end
      return o;
   endfunction

   // Full forward expansion, pushed in reverse round order.
   task automatic push_expected(input logic [0:255] k);
      logic [31:0]  w [0:59];
      logic [31:0]  t;
      logic [7:0]   rc;
      logic [0:127] rk;
      for (int i = 0; i < 8; i++) w[i] = k[32*i +: 32];
      rc = 8'h01;
      for (int i = 8; i < 60; i++) begin
         t = w[i-1];
         if (i % 8 == 0) begin
            t  = m_sub({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
            rc = xt(rc);
         end else if (i % 8 == 4) begin
            t = m_sub(t);
         end
         w[i] = w[i-8] ^ t;
      end
      for (int r = 14; r >= 0; r--) begin
         rk = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
`ifdef AES_INV_KEY_IMC_EN
         if (r >= 1 && r <= 13) rk = m_imc(rk);
`endif
         exp_q.push_back({4'(r), rk});
      end
   endtask

   // Entered and left #1 after a rising edge.
   task automatic do_load(input logic [0:255] k, output int lat);
      int n;
      logic ready_hi;
      n = 0;
      while (!ready && n < 100) begin
         @(posedge clk); #1; n++;
      end
      check("ready_before_load", 132'(ready), 132'(1'b1));
      key_in    = k;
      key_valid = 1'b1;
      @(posedge clk); #1;
      key_valid = 1'b0;
      ready_hi  = ready;
      lat = 0;
      while (!rkey_valid && lat < 50) begin
         @(posedge clk); #1; lat++;
         if (!rkey_valid && ready) ready_hi = 1'b1;
      end
      check("ready_low_fwd", 132'(ready_hi), 132'(1'b0));
   endtask

   task automatic consume(input int mode, output int cyc);
      logic         stalled;
      logic [131:0] held;
      logic [131:0] e;
      int got;
      got = 0; stalled = 1'b0; cyc = 0; held = '0;
      while (got < 15 && cyc < 2000) begin
         rkey_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         if (mode == 1) begin
            key_valid = 1'($urandom_range(0, 1));
            key_in    = {8{$urandom}};
         end
         @(negedge clk);
         if (stalled) check("stall_hold", {rkey_idx, rkey}, held);
         stalled = 1'b0;
         if (rkey_valid && rkey_ready) begin
            if (exp_q.size() == 0) begin
               check("scoreboard_empty", 132'(1'b1), 132'(1'b0));
            end else begin
               e = exp_q.pop_front();
               check("rkey", {rkey_idx, rkey}, e);
            end
            seen_key[rkey_idx] = rkey;
            got++;
         end else if (rkey_valid) begin
            stalled = 1'b1;
            held    = {rkey_idx, rkey};
         end else begin
            check("valid_during_out", 132'(rkey_valid), 132'(1'b1));
         end
         @(posedge clk); #1; cyc++;
      end
      key_valid  = 1'b0;
      rkey_ready = 1'b0;
      check("keys_received", 132'(got), 132'(15));
      check("done_valid_low", 132'(rkey_valid), 132'(1'b0));
      check("done_ready_high", 132'(ready), 132'(1'b1));
      check("scoreboard_drained", 132'(exp_q.size()), 132'(0));
   endtask

   initial begin
      logic [0:255] k_seq;
      int lat, cyc, n;
      k_seq      = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
      rst_n      = 1'b0;
      key_valid  = 1'b0;
      rkey_ready = 1'b0;
      key_in     = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_ready", 132'(ready), 132'(1'b1));
      check("reset_valid", 132'(rkey_valid), 132'(1'b0));
      check("reset_rkey", {rkey_idx, rkey}, 132'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Sequential key, no backpressure.
      push_expected(k_seq);
      do_load(k_seq, lat);
      check("first_key_latency", 132'(lat), 132'(13));
      consume(0, cyc);
      check("no_bp_cycles", 132'(cyc), 132'(15));
      check("kat_seq_idx14", 132'(seen_key[14]), 132'(128'h24fc79ccbf0979e9371ac23c6d68de36));
      check("kat_seq_idx0", 132'(seen_key[0]), 132'(128'h000102030405060708090a0b0c0d0e0f));
`ifndef AES_INV_KEY_IMC_EN
      check("kat_seq_idx1", 132'(seen_key[1]), 132'(128'h101112131415161718191a1b1c1d1e1f));
`endif

      // All-zero key.
      push_expected(256'h0);
      do_load(256'h0, lat);
      check("zero_latency", 132'(lat), 132'(13));
      consume(0, cyc);
`ifndef AES_INV_KEY_IMC_EN
      check("kat_zero_idx2", 132'(seen_key[2]), 132'(128'h62636363626363636263636362636363));
      check("kat_zero_idx3", 132'(seen_key[3]), 132'(128'haafbfbfbaafbfbfbaafbfbfbaafbfbfb));
`endif
      check("kat_zero_idx1", 132'(seen_key[1]), 132'h0);

      // Reset while emitting round 9, then a full fresh run.
      do_load(k_seq, lat);
      rkey_ready = 1'b1;
      n = 0;
      while (rkey_idx != 4'd9 && n < 50) begin
         @(posedge clk); #1; n++;
      end
      check("reached_idx9", 132'(rkey_idx), 132'(4'd9));
      rst_n = 1'b0;
      rkey_ready = 1'b0;
      #1;
      check("midreset_ready", 132'(ready), 132'(1'b1));
      check("midreset_valid", 132'(rkey_valid), 132'(1'b0));
      check("midreset_rkey", {rkey_idx, rkey}, 132'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      push_expected(k_seq);
      do_load(k_seq, lat);
      check("after_reset_latency", 132'(lat), 132'(13));
      consume(0, cyc);

      // Random keys, free-flowing then with backpressure and spurious loads.
      for (int t = 0; t < 5; t++) begin
         key_in = {8{$urandom}};
         k_seq  = key_in;
         push_expected(k_seq);
         do_load(k_seq, lat);
         check("rand_latency", 132'(lat), 132'(13));
         consume((t < 3) ? 0 : 1, cyc);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
